// File: rtl/glb_pkg.sv
// Shared types for the GLB port responder: requester source class, response tag, SRAM web constant.
package glb_pkg;

  localparam int GLB_ID_W = 5;
  localparam logic [3:0] GLB_WEB_NONE = 4'b1111;

  typedef enum logic {
    SRC_IFMAP = 1'b0,
    SRC_IPSUM = 1'b1
  } glb_src_e;

  typedef struct packed {
    glb_src_e              src;
    logic [GLB_ID_W-1:0]   id;
  } glb_rsp_tag_t;

endpackage

// File: rtl/glb_rsp_fifo.sv
// Generic synchronous FIFO with count. Output word is registered storage, valid one cycle after push.
// Backpressure: o_pop_vld/i_pop_rdy handshake; push and pop in one cycle both honoured; no push-when-full by contract.
module glb_rsp_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push_vld,
  input  logic [WIDTH-1:0]          i_push_dat,
  output logic                      o_pop_vld,
  input  logic                      i_pop_rdy,
  output logic [WIDTH-1:0]          o_pop_dat,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;

  assign o_pop_vld = (r_count != '0);
  assign w_pop     = o_pop_vld & i_pop_rdy;
  assign o_count   = r_count;
  // Gate the data so the interface reads 0 when nothing is held.
  assign o_pop_dat = o_pop_vld ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (i_push_vld) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push_vld) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push_vld, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push_vld && (r_count == L_FULL)));

endmodule

// File: rtl/glb_port_responder.sv
// GLB single-port responder: write-priority grant, SRAM drive, tagged read pipe into a credit-protected response FIFO.
// Read latency SRAM_LAT+1 to rsp_valid; reads refused when FIFO+in-flight is full. Optional stats: GLB_ACCESS_STATS_EN.
module glb_port_responder
  import glb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SRAM_AW   = 14,
  parameter int SRAM_LAT  = 1,
  parameter int RSP_DEPTH = 4,
  parameter int ID_W      = GLB_ID_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                glb_write_req,
  input  logic [ADDR_W-1:0]   glb_write_addr,
  input  logic [3:0]          glb_write_web,
  input  logic [DATA_W-1:0]   glb_write_data,
  output logic                glb_write_gnt,
  input  logic                glb_read_req,
  input  logic [ADDR_W-1:0]   glb_read_addr,
  input  logic                glb_read_src,
  input  logic [ID_W-1:0]     glb_read_id,
  output logic                glb_read_gnt,
  output logic                sram_en,
  output logic [3:0]          sram_web,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_src,
  output logic [ID_W-1:0]     rsp_id,
  output logic [31:0]         stat_rd_cnt,
  output logic [31:0]         stat_wr_cnt,
  output logic [31:0]         stat_stall_cnt
);

  localparam int CW    = $clog2(RSP_DEPTH) + 1;
  localparam int TAG_W = $bits(glb_rsp_tag_t);
  localparam int FW    = DATA_W + TAG_W;

  logic                 w_rd_gnt;
  logic                 w_credit_ok;
  logic [CW-1:0]        w_fifo_cnt;
  logic [CW-1:0]        r_inflight;
  logic [SRAM_LAT-1:0]  r_pipe_vld;
  glb_rsp_tag_t         r_pipe_tag [SRAM_LAT];
  logic                 w_push;
  logic [FW-1:0]        w_push_dat;
  logic [FW-1:0]        w_pop_dat;
  glb_rsp_tag_t         w_rsp_tag;
  logic                 w_unused;

  assign w_unused = ^{glb_write_addr[ADDR_W-1:SRAM_AW+2], glb_write_addr[1:0],
                      glb_read_addr[ADDR_W-1:SRAM_AW+2], glb_read_addr[1:0]};

  // Every granted read owns a FIFO slot from grant until it is popped.
  assign w_credit_ok   = ({1'b0, w_fifo_cnt} + {1'b0, r_inflight}) < (CW+1)'(RSP_DEPTH);
  assign glb_write_gnt = glb_write_req;
  assign w_rd_gnt      = glb_read_req & ~glb_write_req & w_credit_ok;
  assign glb_read_gnt  = w_rd_gnt;

  always_comb begin
    sram_en    = 1'b0;
    sram_web   = GLB_WEB_NONE;
    sram_addr  = '0;
    sram_wdata = '0;
    if (glb_write_req) begin
      sram_en    = 1'b1;
      sram_web   = glb_write_web;
      sram_addr  = glb_write_addr[SRAM_AW+1:2];
      sram_wdata = glb_write_data;
    end else if (w_rd_gnt) begin
      sram_en    = 1'b1;
      sram_addr  = glb_read_addr[SRAM_AW+1:2];
    end
  end

  // Tag pipe runs in lockstep with the SRAM read latency; reset drops in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < SRAM_LAT; i++) r_pipe_tag[i] <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd_gnt;
      r_pipe_tag[0] <= '{src: glb_src_e'(glb_read_src), id: glb_read_id};
      for (int i = 1; i < SRAM_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  assign w_push     = r_pipe_vld[SRAM_LAT-1];
  assign w_push_dat = {sram_rdata, r_pipe_tag[SRAM_LAT-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_rd_gnt, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  glb_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push_vld (w_push),
    .i_push_dat (w_push_dat),
    .o_pop_vld  (rsp_valid),
    .i_pop_rdy  (rsp_ready),
    .o_pop_dat  (w_pop_dat),
    .o_count    (w_fifo_cnt)
  );

  assign w_rsp_tag = glb_rsp_tag_t'(w_pop_dat[TAG_W-1:0]);
  assign rsp_data  = w_pop_dat[FW-1:TAG_W];
  assign rsp_src   = w_rsp_tag.src;
  assign rsp_id    = w_rsp_tag.id;

`ifdef GLB_ACCESS_STATS_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_rd_gnt && (r_rd_cnt != '1))                       r_rd_cnt    <= r_rd_cnt + 32'd1;
      if (glb_write_req && (r_wr_cnt != '1))                  r_wr_cnt    <= r_wr_cnt + 32'd1;
      if (glb_read_req && !w_rd_gnt && (r_stall_cnt != '1))   r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stat_rd_cnt    = r_rd_cnt;
  assign stat_wr_cnt    = r_wr_cnt;
  assign stat_stall_cnt = r_stall_cnt;
`else
  assign stat_rd_cnt    = '0;
  assign stat_wr_cnt    = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_glb_port_responder.sv
// Directed bench for glb_port_responder with a behavioural single-port SRAM (1-cycle read latency).
module tb_glb_port_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        glb_write_req;
  logic [31:0] glb_write_addr;
  logic [3:0]  glb_write_web;
  logic [31:0] glb_write_data;
  logic        glb_write_gnt;
  logic        glb_read_req;
  logic [31:0] glb_read_addr;
  logic        glb_read_src;
  logic [4:0]  glb_read_id;
  logic        glb_read_gnt;
  logic        sram_en;
  logic [3:0]  sram_web;
  logic [13:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_src;
  logic [4:0]  rsp_id;
  logic [31:0] stat_rd_cnt;
  logic [31:0] stat_wr_cnt;
  logic [31:0] stat_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  glb_port_responder dut (
    .clk(clk), .rst_n(rst_n),
    .glb_write_req(glb_write_req), .glb_write_addr(glb_write_addr),
    .glb_write_web(glb_write_web), .glb_write_data(glb_write_data),
    .glb_write_gnt(glb_write_gnt),
    .glb_read_req(glb_read_req), .glb_read_addr(glb_read_addr),
    .glb_read_src(glb_read_src), .glb_read_id(glb_read_id),
    .glb_read_gnt(glb_read_gnt),
    .sram_en(sram_en), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_src(rsp_src), .rsp_id(rsp_id),
    .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: byte-masked write, registered read data.
  logic [31:0] mem [int];
  always @(posedge clk) begin
    if (sram_en) begin
      logic [31:0] w;
      w = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : 32'h0;
      if (sram_web == 4'hF) begin
        sram_rdata <= w;
      end else begin
        for (int b = 0; b < 4; b++)
          if (!sram_web[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
        mem[int'(sram_addr)] = w;
      end
    end
  end

  typedef struct {
    logic wr; logic [31:0] wa; logic [3:0] web; logic [31:0] wd;
    logic rd; logic [31:0] ra; logic src; logic [4:0] id; logic rdy;
    logic e_wg; logic e_rg; logic e_en; logic [3:0] e_web; logic [13:0] e_addr;
    logic e_rv; logic [31:0] e_dat; logic e_src; logic [4:0] e_id;
  } vec_t;

  vec_t vt [11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    glb_write_req = 1'b0; glb_write_addr = 32'h0; glb_write_web = 4'hF; glb_write_data = 32'h0;
    glb_read_req = 1'b0; glb_read_addr = 32'h0; glb_read_src = 1'b0; glb_read_id = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_outs"},
          {glb_write_gnt, glb_read_gnt, sram_en, sram_web, sram_addr, sram_wdata,
           rsp_valid, rsp_data, rsp_src, rsp_id},
          {3'b000, 4'hF, 85'd0});
    check({name, "_stats"}, {stat_rd_cnt, stat_wr_cnt, stat_stall_cnt}, 96'd0);
  endtask

  task automatic pulse_reset();
    idle();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("rst_pulse");
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt, got, seen;
    logic [31:0] exp_dat;
    logic        exp_src;

    //            wr    wa        web   wd            rd    ra        src   id     rdy  | wg    rg    en    web   addr     rv    dat           src   id
    vt[0]  = '{1'b1, 32'h40, 4'h0, 32'hDEADBEEF, 1'b0, 32'h0,  1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 14'h10, 1'b0, 32'h0,        1'b0, 5'd0};
    vt[1]  = '{1'b0, 32'h0,  4'hF, 32'h0,        1'b1, 32'h40, 1'b1, 5'd7,  1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 14'h10, 1'b0, 32'h0,        1'b0, 5'd0};
    vt[2]  = '{1'b0, 32'h0,  4'hF, 32'h0,        1'b0, 32'h0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 14'h0,  1'b0, 32'h0,        1'b0, 5'd0};
    vt[3]  = '{1'b0, 32'h0,  4'hF, 32'h0,        1'b0, 32'h0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 14'h0,  1'b1, 32'hDEADBEEF, 1'b1, 5'd7};
    vt[4]  = '{1'b1, 32'h80, 4'h0, 32'hFFFFFFFF, 1'b1, 32'h80, 1'b0, 5'd3,  1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 14'h20, 1'b0, 32'h0,        1'b0, 5'd0};
    vt[5]  = '{1'b0, 32'h0,  4'hF, 32'h0,        1'b1, 32'h80, 1'b0, 5'd3,  1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 14'h20, 1'b0, 32'h0,        1'b0, 5'd0};
    vt[6]  = '{1'b1, 32'h82, 4'hC, 32'h00001234, 1'b0, 32'h0,  1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b1, 4'hC, 14'h20, 1'b0, 32'h0,        1'b0, 5'd0};
    vt[7]  = '{1'b0, 32'h0,  4'hF, 32'h0,        1'b1, 32'h81, 1'b1, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 14'h20, 1'b1, 32'hFFFFFFFF, 1'b0, 5'd3};
    vt[8]  = '{1'b0, 32'h0,  4'hF, 32'h0,        1'b0, 32'h0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 14'h0,  1'b0, 32'h0,        1'b0, 5'd0};
    vt[9]  = '{1'b0, 32'h0,  4'hF, 32'h0,        1'b0, 32'h0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 14'h0,  1'b1, 32'hFFFF1234, 1'b1, 5'd31};
    vt[10] = '{1'b0, 32'h0,  4'hF, 32'h0,        1'b0, 32'h0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 14'h0,  1'b0, 32'h0,        1'b0, 5'd0};

    idle();
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    check_reset_outputs("init_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Table: write/read round trip, write-wins collision, partial byte write.
    for (int i = 0; i < 11; i++) begin
      glb_write_req = vt[i].wr; glb_write_addr = vt[i].wa; glb_write_web = vt[i].web;
      glb_write_data = vt[i].wd; glb_read_req = vt[i].rd; glb_read_addr = vt[i].ra;
      glb_read_src = vt[i].src; glb_read_id = vt[i].id; rsp_ready = vt[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_ctl", i),
            {glb_write_gnt, glb_read_gnt, sram_en, sram_web, sram_addr, rsp_valid},
            {vt[i].e_wg, vt[i].e_rg, vt[i].e_en, vt[i].e_web, vt[i].e_addr, vt[i].e_rv});
      if (vt[i].e_rv)
        check($sformatf("vec%0d_rsp", i), {rsp_data, rsp_src, rsp_id},
              {vt[i].e_dat, vt[i].e_src, vt[i].e_id});
      if (vt[i].e_wg)
        check($sformatf("vec%0d_wdata", i), sram_wdata, vt[i].wd);
      tick();
    end

    // Credit backpressure: 6 reads with consumer stalled.
    idle();
    for (int i = 0; i < 6; i++) begin
      glb_write_req = 1'b1; glb_write_addr = 32'h100 + 32'(4*i);
      glb_write_web = 4'h0; glb_write_data = 32'hA0000000 + 32'(i);
      tick();
    end
    idle();
    rsp_ready = 1'b0;
    nxt = 0;
    for (int c = 0; c < 8; c++) begin
      glb_read_req = 1'b1; glb_read_addr = 32'h100 + 32'(4*nxt);
      glb_read_src = nxt[0]; glb_read_id = 5'(10 + nxt);
      @(negedge clk);
      check($sformatf("bp_gnt_c%0d", c), glb_read_gnt, (c < 4) ? 1'b1 : 1'b0);
      if (glb_read_gnt) nxt++;
      tick();
    end
    check("bp_granted_while_stalled", nxt, 4);
    check("bp_held_rsp", {rsp_valid, rsp_data, rsp_id}, {1'b1, 32'hA0000000, 5'd10});
    @(negedge clk);
    check("bp_held_rsp_again", {rsp_valid, rsp_data, rsp_id}, {1'b1, 32'hA0000000, 5'd10});
    tick();

    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && (got < 6 || nxt < 6); c++) begin
      if (nxt < 6) begin
        glb_read_req = 1'b1; glb_read_addr = 32'h100 + 32'(4*nxt);
        glb_read_src = nxt[0]; glb_read_id = 5'(10 + nxt);
      end else begin
        idle();
      end
      @(negedge clk);
      if (rsp_valid) begin
        exp_dat = 32'hA0000000 + 32'(got);
        exp_src = got[0];
        check($sformatf("bp_rsp%0d", got), {rsp_data, rsp_src, rsp_id},
              {exp_dat, exp_src, 5'(10 + got)});
        got++;
      end
      if (glb_read_gnt) nxt++;
      tick();
    end
    check("bp_total_rsp", got, 6);
    check("bp_total_gnt", nxt, 6);
    idle();
    tick();

    // Reset one cycle after a read grant drops the response.
    glb_read_req = 1'b1; glb_read_addr = 32'h40; glb_read_src = 1'b1; glb_read_id = 5'd7;
    @(negedge clk);
    check("rst_mid_gnt", glb_read_gnt, 1'b1);
    tick();
    idle();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("rst_mid");
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
      tick();
    end
    check("rst_mid_no_rsp", seen, 0);

    // Statistics: 3 writes, 5 read grants, 2 refused read cycles.
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      glb_write_req = 1'b1; glb_write_addr = 32'h200 + 32'(4*i);
      glb_write_web = 4'h0; glb_write_data = 32'(i);
      tick();
    end
    idle();
    rsp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      glb_read_req = 1'b1; glb_read_addr = 32'h200; glb_read_id = 5'(c);
      tick();
    end
    idle();
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    glb_read_req = 1'b1; glb_read_addr = 32'h204;
    @(negedge clk);
    check("stat_last_gnt", glb_read_gnt, 1'b1);
    tick();
    idle();
    for (int c = 0; c < 4; c++) tick();
    @(negedge clk);
`ifdef GLB_ACCESS_STATS_EN
    check("stat_wr", stat_wr_cnt, 32'd3);
    check("stat_rd", stat_rd_cnt, 32'd5);
    check("stat_stall", stat_stall_cnt, 32'd2);
`else
    check("stat_wr", stat_wr_cnt, 32'd0);
    check("stat_rd", stat_rd_cnt, 32'd0);
    check("stat_stall", stat_stall_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/glb_port_responder.md
Name: glb_port_responder

Overview:
- GLB-side responder for the token engine's single shared GLB port.
- Takes the granted write or read each cycle (opsum writes; ifmap/ipsum reads) and drives the single-port GLB SRAM macro.
- Tracks in-flight reads by requester tag (source class + lane index) and returns read data through a credit-protected response FIFO, so the token engine can route each word back to the permitted PE lane.

Parameters:
- ADDR_W, 32, width of byte address from the arbiter
- DATA_W, 32, GLB word width
- SRAM_AW, 14, SRAM word-address width; sram_addr = addr[SRAM_AW+1:2]
- SRAM_LAT, 1, SRAM read latency in cycles (1..3)
- RSP_DEPTH, 4, response FIFO depth (power of 2, >= SRAM_LAT+1)
- ID_W, 5, lane index width (32 lanes)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- glb_write_req  in  1  write request
- glb_write_addr  in  ADDR_W  write byte address
- glb_write_web  in  4  per-byte write enable, active-low (4'b1111 = no byte written)
- glb_write_data  in  DATA_W  write data
- glb_write_gnt  out  1  write accepted this cycle
- glb_read_req  in  1  read request
- glb_read_addr  in  ADDR_W  read byte address
- glb_read_src  in  1  0 = ifmap, 1 = ipsum
- glb_read_id  in  ID_W  requesting lane
- glb_read_gnt  out  1  read accepted this cycle
- sram_en  out  1  SRAM access enable
- sram_web  out  4  SRAM byte write enable, active-low
- sram_addr  out  SRAM_AW  SRAM word address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid SRAM_LAT cycles after a read
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  DATA_W  read data
- rsp_src  out  1  source class of the response
- rsp_id  out  ID_W  lane of the response
- stat_rd_cnt  out  32  granted reads (optional feature)
- stat_wr_cnt  out  32  granted writes (optional feature)
- stat_stall_cnt  out  32  cycles a read was refused (optional feature)

Behaviour:
- Reset (async, rst_n = 0): clears in-flight pipe, FIFO, credit counter and stats. All outputs are 0 except sram_web = 4'b1111.
- Priority:
  - Write wins. glb_write_gnt = glb_write_req, combinational; a write is never refused.
  - glb_read_gnt = glb_read_req & !glb_write_req & credit_ok.
  - Both requests in one cycle: write granted, read not granted; the requester holds and retries.
- Credits: credit_ok = (fifo_count + inflight) < RSP_DEPTH. inflight increments on read grant and decrements when data is pushed; simultaneous events net out.
- SRAM drive (combinational in the grant cycle):
  - Write: sram_en = 1, sram_web = glb_write_web, addr/data from the write port.
  - Read: sram_en = 1, sram_web = 4'b1111.
  - Idle: sram_en = 0, sram_web = 4'b1111, addr/wdata = 0.
  - Byte address bits [1:0] are ignored.
- In-flight pipe:
  - Shift register of SRAM_LAT stages holding {valid, src, id}.
  - Stage SRAM_LAT valid pushes {sram_rdata, src, id} into the FIFO at that clock edge.
  - Read granted in cycle T gives rsp_valid in cycle T+SRAM_LAT+1 when the FIFO was empty (SRAM_LAT = 1: 2-cycle latency).
- Response FIFO:
  - Standard valid/ready; pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle are both honoured; count unchanged.
  - rsp_* are held stable while rsp_valid & !rsp_ready.
  - Responses are returned strictly in grant order.
  - Pointers wrap modulo RSP_DEPTH.
  - Overflow is impossible by credit; the push-when-full assertion must never fire.
- Ordering: read-after-write to the same address in a later cycle returns the new data, because the SRAM single port is in order.
- Reset mid-operation: in-flight reads are dropped. Any sram_rdata arriving after reset is ignored, and no rsp_valid is produced for pre-reset grants.

Optional Feature:
- Macro GLB_ACCESS_STATS_EN.
- Defined: three 32-bit saturating counters.
  - stat_rd_cnt +1 per read grant.
  - stat_wr_cnt +1 per write grant.
  - stat_stall_cnt +1 per cycle with glb_read_req & !glb_read_gnt.
  - Counters hold at 32'hFFFFFFFF and clear on reset.
- Undefined: no counter logic; stat_* tied to 0. Ports exist in both builds.

Decomposition:
- Package glb_pkg:
  - glb_src_e (SRC_IFMAP = 0, SRC_IPSUM = 1)
  - glb_rsp_tag_t struct {src, id}
  - GLB_WEB_NONE = 4'b1111
- Sub-module glb_rsp_fifo: parameterised synchronous FIFO for {data, tag} with count output, instantiated once.

Test Plan:
- Write addr 0x40, web 4'b0000, data 0xDEADBEEF; then read 0x40, src 1, id 7 → glb_read_gnt = 1, rsp_valid 2 cycles later with data 0xDEADBEEF, rsp_src 1, rsp_id 7.
- Write and read requested in the same cycle → glb_write_gnt = 1, glb_read_gnt = 0, sram_web = write web; read granted the next cycle.
- Partial write web 4'b1100, data 0x0000_1234 over 0xFFFF_FFFF → read returns 0xFFFF_1234.
- rsp_ready = 0, 6 back-to-back reads → exactly RSP_DEPTH = 4 granted, then glb_read_gnt = 0; after raising rsp_ready all 4 return in order with ids intact, and the remaining reads are then granted.
- Assert rst_n low one cycle after a read grant → no rsp_valid afterward; all outputs at reset values.
- With GLB_ACCESS_STATS_EN: 3 writes, 5 reads, 2 refused read cycles → stat_wr_cnt = 3, stat_rd_cnt = 5, stat_stall_cnt = 2; without the macro, all stat_* read 0.
